// File: rtl/md_pkg.sv
// Shared encodings and constants for the multiply/divide unit.
package md_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } md_state_e;

  localparam int unsigned MD_ITER = 32;
  localparam logic [31:0] MD_DIV0_LO = 32'hFFFF_FFFF;

  function automatic logic md_is_signed(input md_op_e op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/md_iter_core.sv
// Shared 64-bit accumulator: one shift-add (multiply) or restoring
// subtract (divide) step per cycle on magnitudes.
module md_iter_core #(
  parameter int unsigned W = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load,
  input  logic           step,
  input  logic           div_mode,
  input  logic [W-1:0]   load_lo,
  input  logic [W-1:0]   load_opnd,
  output logic [2*W-1:0] acc
);

  logic [2*W-1:0] acc_q, acc_d;
  logic [W-1:0]   opnd_q, opnd_d;

  logic [W:0]     mul_sum;
  logic [W:0]     div_shifted;
  logic [W+1:0]   div_diff;
  logic           div_ge;
  logic [W-1:0]   div_rem;
  logic           unused_diff_msb;

  // Multiply: {hi, lo} holds partial product over the remaining multiplier bits.
  assign mul_sum = acc_q[0] ? ({1'b0, acc_q[2*W-1:W]} + {1'b0, opnd_q})
                            : {1'b0, acc_q[2*W-1:W]};

  // Divide: {rem, quot} shifts left; quotient bits enter at the bottom.
  assign div_shifted     = {acc_q[2*W-1:W], acc_q[W-1]};
  assign div_diff        = {1'b0, div_shifted} - {2'b00, opnd_q};
  assign div_ge          = ~div_diff[W+1];
  assign div_rem         = div_ge ? div_diff[W-1:0] : div_shifted[W-1:0];
  assign unused_diff_msb = div_diff[W];

  always_comb begin
    acc_d  = acc_q;
    opnd_d = opnd_q;
    if (load) begin
      acc_d  = {{W{1'b0}}, load_lo};
      opnd_d = load_opnd;
    end else if (step) begin
      if (div_mode) acc_d = {div_rem, acc_q[W-2:0], div_ge};
      else          acc_d = {mul_sum, acc_q[W-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      opnd_q <= '0;
    end else begin
      acc_q  <= acc_d;
      opnd_q <= opnd_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO. Define MD_FAST_MULT_EN for a
// single-cycle multiplier; division stays iterative either way.
module md_unit
  import md_pkg::*;
#(
  parameter int unsigned W     = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [2:0]   md_op,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  input  logic         flush,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] hi_num,
  output logic [W-1:0] lo_num
);

  md_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic           busy_q, busy_d, done_q, done_d;
  logic [W-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic           neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;
  logic           div0_q, div0_d, is_div_q, is_div_d;

  md_op_e         op;
  logic           a_neg, b_neg, op_is_div;
  logic [W-1:0]   a_mag, b_mag;
  logic           core_load, core_step, core_div;
  logic [2*W-1:0] acc, acc_neg;
  logic [W-1:0]   quot, rem;

  assign op        = md_op_e'(md_op);
  assign a_neg     = md_is_signed(op) & op_a[W-1];
  assign b_neg     = md_is_signed(op) & op_b[W-1];
  assign a_mag     = a_neg ? -op_a : op_a;
  assign b_mag     = b_neg ? -op_b : op_b;
  assign op_is_div = (op == MD_DIV) || (op == MD_DIVU);
  assign core_div  = (state_q == ST_IDLE) ? op_is_div : (state_q == ST_DIV);

  assign acc_neg = -acc;
  assign quot    = acc[W-1:0];
  assign rem     = acc[2*W-1:W];

`ifdef MD_FAST_MULT_EN
  logic [2*W-1:0] fast_mag, fast_prod;
  assign fast_mag  = {{W{1'b0}}, a_mag} * {{W{1'b0}}, b_mag};
  assign fast_prod = (a_neg ^ b_neg) ? -fast_mag : fast_mag;
`endif

  md_iter_core #(
    .W (W)
  ) u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (core_load),
    .step      (core_step),
    .div_mode  (core_div),
    .load_lo   (core_div ? a_mag : b_mag),
    .load_opnd (core_div ? b_mag : a_mag),
    .acc       (acc)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    hi_d      = hi_q;
    lo_d      = lo_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    is_div_d  = is_div_q;
    core_load = 1'b0;
    core_step = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start && !flush) begin
          unique case (op)
            MD_MULT, MD_MULTU: begin
`ifdef MD_FAST_MULT_EN
              {hi_d, lo_d} = fast_prod;
              done_d       = 1'b1;
`else
              state_d   = ST_MUL;
              busy_d    = 1'b1;
              cnt_d     = '0;
              core_load = 1'b1;
              neg_res_d = a_neg ^ b_neg;
              is_div_d  = 1'b0;
`endif
            end
            MD_DIV, MD_DIVU: begin
              state_d   = ST_DIV;
              busy_d    = 1'b1;
              cnt_d     = '0;
              core_load = 1'b1;
              neg_res_d = a_neg ^ b_neg;
              neg_rem_d = a_neg;
              div0_d    = (op_b == '0);
              is_div_d  = 1'b1;
            end
            MD_MTHI: hi_d = op_a;
            MD_MTLO: lo_d = op_a;
            default: ;
          endcase
        end
      end
      ST_MUL, ST_DIV: begin
        core_step = 1'b1;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(MD_ITER - 1)) state_d = ST_FIX;
      end
      ST_FIX: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        if (is_div_q) begin
          // Magnitude remainder negated back gives HI = op_a on divide-by-zero.
          lo_d = div0_q ? W'(MD_DIV0_LO) : (neg_res_q ? -quot : quot);
          hi_d = neg_rem_q ? -rem : rem;
        end else begin
          {hi_d, lo_d} = neg_res_q ? acc_neg : acc;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (flush && (state_q != ST_IDLE)) begin
      state_d   = ST_IDLE;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      cnt_d     = '0;
      core_step = 1'b0;
      hi_d      = hi_q;
      lo_d      = lo_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      is_div_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
      is_div_q  <= is_div_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign hi_num = hi_q;
  assign lo_num = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed table, corner sequences and
// randomized ops against an arithmetic reference model.
module tb_md_unit;

  localparam logic [2:0] OP_NONE = 3'd0, OP_MULT = 3'd1, OP_MULTU = 3'd2, OP_DIV = 3'd3;
  localparam logic [2:0] OP_DIVU = 3'd4, OP_MTHI = 3'd5, OP_MTLO = 3'd6;
`ifdef MD_FAST_MULT_EN
  localparam int MUL_CYC = 0;
`else
  localparam int MUL_CYC = 33;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  md_op = '0;
  logic [31:0] op_a = '0, op_b = '0;
  logic        flush = 1'b0;
  logic        busy, done;
  logic [31:0] hi_num, lo_num;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] m_hi = '0, m_lo = '0;

  always #5 clk = ~clk;

  md_unit u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .md_op  (md_op),
    .op_a   (op_a),
    .op_b   (op_b),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .hi_num (hi_num),
    .lo_num (lo_num)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, exp_hi, exp_lo;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [31:0] hi,
                                            input logic [31:0] lo);
    longint sa, sb, q, r;
    logic [63:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      OP_MULT:  res = sa * sb;
      OP_MULTU: res = {32'h0, a} * {32'h0, b};
      OP_DIV: begin
        if (b == 0) res = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      OP_DIVU:  res = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      OP_MTHI:  res = {a, lo};
      OP_MTLO:  res = {hi, a};
      default:  res = {hi, lo};
    endcase
    return res;
  endfunction

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 5))
      0:       return 32'h8000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'($urandom_range(0, 20));
      3:       return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  // Caller is idle at #1 after a rising edge; returns at the same phase.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input string name);
    int n, exp_cyc;
    logic exp_done;
    exp_cyc  = (op == OP_MULT || op == OP_MULTU) ? MUL_CYC :
               (op == OP_DIV || op == OP_DIVU) ? 33 : 0;
    exp_done = (op >= OP_MULT) && (op <= OP_DIVU);
    start = 1'b1; md_op = op; op_a = a; op_b = b;
    @(posedge clk); #1;
    start = 1'b0; md_op = OP_NONE; op_a = $urandom; op_b = $urandom;
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      @(posedge clk); #1;
    end
    check({name, " busy_cycles"}, 64'(n), 64'(exp_cyc));
    check({name, " done"}, 64'(done), 64'(exp_done));
    check({name, " hi"}, 64'(hi_num), 64'(eh));
    check({name, " lo"}, 64'(lo_num), 64'(el));
    @(posedge clk); #1;
    check({name, " done_drop"}, 64'(done), 64'h0);
    m_hi = eh;
    m_lo = el;
  endtask

  initial begin
    vec_t vecs[$];
    logic [63:0] exp;
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    int n;

    vecs.push_back('{OP_MULT,  32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA});
    vecs.push_back('{OP_MULTU, 32'hFFFF_FFFE, 32'd3,        32'h0000_0002, 32'hFFFF_FFFA});
    vecs.push_back('{OP_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD});
    vecs.push_back('{OP_DIVU,  32'd7,         32'd2,        32'd1,         32'd3});
    vecs.push_back('{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0,        32'h8000_0000});
    vecs.push_back('{OP_DIV,   32'd100,       32'd0,        32'h0000_0064, 32'hFFFF_FFFF});
    vecs.push_back('{OP_MTLO,  32'hCAFE_F00D, 32'd9,        32'h0000_0064, 32'hCAFE_F00D});
    vecs.push_back('{OP_MTHI,  32'h1234_5678, 32'd9,        32'h1234_5678, 32'hCAFE_F00D});
    vecs.push_back('{OP_NONE,  32'd5,         32'd5,        32'h1234_5678, 32'hCAFE_F00D});

    #12;
    check("reset hi", 64'(hi_num), 64'h0);
    check("reset lo", 64'(lo_num), 64'h0);
    check("reset busy", 64'(busy), 64'h0);
    check("reset done", 64'(done), 64'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i])
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_hi, vecs[i].exp_lo,
             $sformatf("vec%0d", i));

    // Flush on busy cycle 10: HI/LO keep the MTHI/MTLO values, no done.
    start = 1'b1; md_op = OP_DIV; op_a = 32'd1000; op_b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("flush busy_before", 64'(busy), 64'h1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush busy", 64'(busy), 64'h0);
    check("flush done", 64'(done), 64'h0);
    check("flush hi", 64'(hi_num), 64'(m_hi));
    check("flush lo", 64'(lo_num), 64'(m_lo));
    @(posedge clk); #1;
    check("flush done_late", 64'(done), 64'h0);

    // Flush together with start in IDLE: MTLO must be dropped.
    start = 1'b1; flush = 1'b1; md_op = OP_MTLO; op_a = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    check("flush_start lo", 64'(lo_num), 64'(m_lo));
    check("flush_start busy", 64'(busy), 64'h0);

    // Start while busy is ignored and not queued.
    start = 1'b1; md_op = OP_DIVU; op_a = 32'd7; op_b = 32'd2;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1; md_op = OP_MULTU; op_a = 32'hFFFF_FFFF; op_b = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    start = 1'b0; md_op = OP_NONE;
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      @(posedge clk); #1;
    end
    check("ign busy_cycles", 64'(n), 64'd28);
    check("ign done", 64'(done), 64'h1);
    check("ign hi", 64'(hi_num), 64'd1);
    check("ign lo", 64'(lo_num), 64'd3);
    repeat (3) @(posedge clk);
    #1;
    check("ign no_queue busy", 64'(busy), 64'h0);
    check("ign no_queue lo", 64'(lo_num), 64'd3);
    m_hi = 32'd1; m_lo = 32'd3;

    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 6));
      ra  = pick_val();
      rb  = ($urandom_range(0, 7) == 0) ? 32'h0 : pick_val();
      exp = ref_model(rop, ra, rb, m_hi, m_lo);
      run_op(rop, ra, rb, exp[63:32], exp[31:0], $sformatf("rnd%0d op%0d", i, rop));
    end

    // Asynchronous reset mid-divide clears state without a clock edge.
    start = 1'b1; md_op = OP_DIV; op_a = 32'hFFFF_F000; op_b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst hi", 64'(hi_num), 64'h0);
    check("arst lo", 64'(lo_num), 64'h0);
    check("arst busy", 64'(busy), 64'h0);
    check("arst done", 64'(done), 64'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_hi = '0; m_lo = '0;
    run_op(OP_DIVU, 32'd50, 32'd8, 32'd2, 32'd6, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multi-cycle multiply/divide unit that owns the HI/LO registers.
- It is the producer side of the EX-stage HI/LO interface: it accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO requests from EX and drives hi_num/lo_num back into EX.
- Busy drives the hazard unit, which stalls ID/EX while an operation is in flight.

Parameters:
- W, 32, operand and HI/LO width.
- CNT_W, 6, iteration counter width (must hold W+1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request valid, sampled on rising clk.
- md_op  in  3  0=NONE 1=MULT 2=MULTU 3=DIV 4=DIVU 5=MTHI 6=MTLO.
- op_a  in  W  rs value (dividend / multiplicand / MTHI-MTLO data).
- op_b  in  W  rt value (divisor / multiplier).
- flush  in  1  cancel any in-flight operation.
- busy  out  1  operation in progress; new starts ignored.
- done  out  1  one-cycle pulse when HI/LO are written by MULT/DIV.
- hi_num  out  W  HI register.
- lo_num  out  W  LO register.

Behaviour:
- Reset (async, rst_n=0): hi_num=0, lo_num=0, busy=0, done=0, state=IDLE, counter=0.
- States: IDLE, MUL, DIV, FIX.
  - IDLE with start=1 and flush=0:
    - MULT/MULTU -> MUL.
    - DIV/DIVU -> DIV.
    - MTHI/MTLO write hi_num/lo_num at that edge and stay in IDLE; busy never rises.
    - NONE is ignored.
  - On accept, latch |op_a| and |op_b| (signed ops) or raw values (unsigned ops), plus the result-sign flags and the op.
  - MUL: radix-2 shift-add, one bit per cycle, 32 cycles -> FIX.
  - DIV: restoring division, one quotient bit per cycle, 32 cycles -> FIX.
  - FIX: negate the product when operand signs differ (MULT). For DIV, negate the quotient when signs differ and give the remainder the sign of the dividend. Write HI/LO, then -> IDLE.
- Latency: busy=1 for exactly 33 cycles after the accept edge. HI/LO are updated at the FIX edge. done=1 for the following single cycle.
- Results:
  - MULT/MULTU: {HI,LO} = 64-bit product.
  - DIV/DIVU: LO = quotient, HI = remainder.
- Divide by zero (op_b=0): no exception, same latency; LO=32'hFFFFFFFF, HI=op_a.
- Signed overflow (0x80000000 / -1): LO=0x80000000, HI=0.
- start while busy: ignored; no queuing. The hazard unit must hold the request.
- flush:
  - Any non-IDLE state -> IDLE at the next edge. HI/LO keep their pre-op values and no done pulse is issued.
  - flush together with start in IDLE: flush wins, so start is ignored (including MTHI/MTLO).
- Reset mid-operation: immediate clear as above; the partial result is discarded.
- hi_num/lo_num are registered outputs only, with no combinational path from inputs.

Optional Feature:
- Macro MD_FAST_MULT_EN.
- Defined:
  - MULT/MULTU use a single-cycle 64-bit multiplier. HI/LO are written at the accept edge, done pulses the next cycle, and busy stays 0. MUL state is unused.
  - DIV is unchanged.
- Undefined: 33-cycle iterative multiply as above.

Decomposition:
- Shared package md_pkg holds:
  - md_op encodings (MD_NONE..MD_MTLO).
  - State encodings (ST_IDLE, ST_MUL, ST_DIV, ST_FIX).
  - Iteration count constant MD_ITER=32.
  - Divide-by-zero LO constant 32'hFFFFFFFF.
- One sub-module, md_iter_core: shared 64-bit accumulator/shift datapath doing one add-or-subtract step per cycle in either mode.
- md_unit keeps the FSM, sign fix-up, HI/LO registers and handshake.

Test Plan:
- Reset: assert rst_n=0 mid-DIV -> hi_num=lo_num=0, busy=0, done=0 immediately, without waiting for clk.
- MULT op_a=0xFFFFFFFE, op_b=3 -> after 33 busy cycles, HI=0xFFFFFFFF, LO=0xFFFFFFFA, done single pulse. With MD_FAST_MULT_EN, the same result with busy never high.
- MULTU op_a=0xFFFFFFFE, op_b=3 -> HI=0x00000002, LO=0xFFFFFFFA.
- Signed divides:
  - DIV op_a=-7 (0xFFFFFFF9), op_b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIVU 7/2 -> LO=3, HI=1.
  - DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIV op_a=100, op_b=0 -> LO=0xFFFFFFFF, HI=0x00000064 after 33 cycles.
- Flush and busy handling:
  - MTHI 0x12345678 in IDLE -> hi_num=0x12345678 next edge, busy stays 0.
  - Start DIV, pulse flush on busy cycle 10 -> busy=0 next cycle, HI still 0x12345678, no done.
  - A start asserted during busy is ignored: HI/LO match the first op only.
